// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU and a synchronous
// byte-lane RAM; read data returns the cycle after re.
//   addr  : word address          we/be/wdata : write strobe, lanes, data
//   re    : read strobe           rdata       : read data (next cycle)
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              re;
  logic [31:0]       rdata;

  modport master (
    output addr, we, be, wdata, re,
    input  rdata
  );

  modport slave (
    input  addr, we, be, wdata, re,
    output rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: store lane steering, two-cycle loads
// with sign/zero extension, misalign/illegal drop, event counters.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid..rd_in     : EX/MEM request (op, size, address, data, rd)
//   stall               : freeze front of pipe during load issue
//   out_valid/rdata/rd  : MEM/WB load result
//   misalign            : pulse when a bad request is dropped
//   dmem                : data-memory bus (master side)
//   store_cnt, load_cnt : wrapping committed-op counters
module mem_stage_lsu #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             out_valid,
  output logic [31:0]      out_rdata,
  output logic [4:0]       out_rd,
  output logic             misalign,
  mem_stage_lsu_if.master  dmem,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] load_cnt
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t     state;
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic [4:0] rd_q;

  logic op;
  logic mis;
  logic bad;
  logic idle;
  logic st_go;
  logic ld_go;

  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;

  // upper address bits select nothing inside this memory
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign op  = in_valid & (mem_read | mem_write);
  assign mis = ((size == 2'b01) & addr[0]) |
               ((size == 2'b10) & (|addr[1:0]));
  assign bad = op & ((mem_read & mem_write) |
                     (size == 2'b11) | mis);

  // a request is only acted on in IDLE; LOAD_WAIT sees the
  // held load again and must not re-issue it
  assign idle  = (state == IDLE) & ~rst;
  assign st_go = idle & op & ~bad & mem_write;
  assign ld_go = idle & op & ~bad & mem_read;

  assign stall    = ld_go;
  assign misalign = idle & bad;

  always_comb begin
    be_c = '0;
    wd_c = '0;
    if (st_go) begin
      unique case (1'b1)
        size == 2'b00: begin
          be_c = 4'b0001 << addr[1:0];
          wd_c = {4{wdata[7:0]}};
        end
        size == 2'b01: begin
          be_c = addr[1] ? 4'b1100 : 4'b0011;
          wd_c = {2{wdata[15:0]}};
        end
        default: begin
          be_c = 4'b1111;
          wd_c = wdata;
        end
      endcase
    end
  end

  assign dmem.we    = st_go;
  assign dmem.re    = ld_go;
  assign dmem.be    = be_c;
  assign dmem.wdata = wd_c;
  assign dmem.addr  = (st_go | ld_go) ?
                      addr[ADDR_W+1:2] : '0;

  always_comb begin
    byte_v = dmem.rdata[7:0];
    unique case (off_q)
      2'd0: byte_v = dmem.rdata[7:0];
      2'd1: byte_v = dmem.rdata[15:8];
      2'd2: byte_v = dmem.rdata[23:16];
      default: byte_v = dmem.rdata[31:24];
    endcase
    half_v = off_q[1] ? dmem.rdata[31:16]
                      : dmem.rdata[15:0];
    unique case (size_q)
      2'b00: ext = {{24{~uns_q & byte_v[7]}}, byte_v};
      2'b01: ext = {{16{~uns_q & half_v[15]}}, half_v};
      default: ext = dmem.rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_rd    <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      store_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (st_go)
        store_cnt <= store_cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (ld_go) begin
            off_q  <= addr[1:0];
            size_q <= size;
            uns_q  <= is_unsigned;
            rd_q   <= rd_in;
            state  <= LOAD_WAIT;
          end
        end
        default: begin
          out_rdata <= ext;
          out_rd    <= rd_q;
          out_valid <= 1'b1;
          load_cnt  <= load_cnt + CNT_W'(1);
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a synchronous
// byte-lane RAM model and hand-computed expectations.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_in;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        misalign;
  logic [15:0] store_cnt;
  logic [15:0] load_cnt;

  int n_chk;
  int n_fail;
  int exp_st;

  logic [31:0] mem [1024];

  mem_stage_lsu_if #(.ADDR_W(10)) bus ();

  mem_stage_lsu #(
    .ADDR_W(10),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .is_unsigned(is_unsigned),
    .addr       (addr),
    .wdata      (wdata),
    .rd_in      (rd_in),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_rdata  (out_rdata),
    .out_rd     (out_rd),
    .misalign   (misalign),
    .dmem       (bus.master),
    .store_cnt  (store_cnt),
    .load_cnt   (load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.we) begin
      for (int i = 0; i < 4; i++)
        if (bus.be[i])
          mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
    if (bus.re)
      bus.rdata <= mem[bus.addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] r);
    in_valid    = 1'b1;
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    is_unsigned = uns;
    addr        = a;
    wdata       = wd;
    rd_in       = r;
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [3:0] ebe,
                          input logic [31:0] ewd);
    req(1'b0, 1'b1, sz, 1'b0, a, wd, 5'd0);
    @(negedge clk);
    check({tag, ".we"}, 32'(bus.we), 32'd1);
    check({tag, ".be"}, 32'(bus.be), 32'(ebe));
    check({tag, ".wd"}, bus.wdata, ewd);
    check({tag, ".addr"}, 32'(bus.addr), 32'(a[11:2]));
    check({tag, ".stall"}, 32'(stall), 32'd0);
    exp_st++;
    next_cyc();
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [4:0] r,
                         input logic [31:0] exp);
    req(1'b1, 1'b0, sz, uns, a, 32'd0, r);
    @(negedge clk);
    check({tag, ".stall0"}, 32'(stall), 32'd1);
    check({tag, ".re"}, 32'(bus.re), 32'd1);
    next_cyc();
    @(negedge clk);
    check({tag, ".stall1"}, 32'(stall), 32'd0);
    check({tag, ".ov1"}, 32'(out_valid), 32'd0);
    next_cyc();
    idle();
    @(negedge clk);
    check({tag, ".ov2"}, 32'(out_valid), 32'd1);
    check({tag, ".data"}, out_rdata, exp);
    check({tag, ".rd"}, 32'(out_rd), 32'(r));
    next_cyc();
  endtask

  task automatic do_bad(input string tag, input logic rd,
                        input logic wr, input logic [1:0] sz,
                        input logic [31:0] a);
    req(rd, wr, sz, 1'b0, a, 32'hFFFF_FFFF, 5'd1);
    @(negedge clk);
    check({tag, ".mis"}, 32'(misalign), 32'd1);
    check({tag, ".we"}, 32'(bus.we), 32'd0);
    check({tag, ".re"}, 32'(bus.re), 32'd0);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    next_cyc();
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_st = 0;
    rst    = 1'b1;
    idle();
    size        = 2'b00;
    is_unsigned = 1'b0;
    addr        = '0;
    wdata       = '0;
    rd_in       = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.mis", 32'(misalign), 32'd0);
    check("rst.we", 32'(bus.we), 32'd0);
    check("rst.re", 32'(bus.re), 32'd0);
    check("rst.be", 32'(bus.be), 32'd0);
    check("rst.wd", bus.wdata, 32'd0);
    check("rst.addr", 32'(bus.addr), 32'd0);
    check("rst.rdata", out_rdata, 32'd0);
    check("rst.rd", 32'(out_rd), 32'd0);
    check("rst.scnt", 32'(store_cnt), 32'd0);
    check("rst.lcnt", 32'(load_cnt), 32'd0);
    next_cyc();

    do_store("pre1", 2'b10, 32'd4, 32'h1122_3344,
             4'b1111, 32'h1122_3344);
    do_store("pre2", 2'b10, 32'd8, 32'hCAFE_BABE,
             4'b1111, 32'hCAFE_BABE);
    idle();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    exp_st = 0;
    @(negedge clk);
    check("rst2.scnt", 32'(store_cnt), 32'd0);
    next_cyc();

    do_store("sb8", 2'b00, 32'd8, 32'h1234_5678,
             4'b0001, 32'h7878_7878);
    idle();
    @(negedge clk);
    check("sb8.we_off", 32'(bus.we), 32'd0);
    check("sb8.be_off", 32'(bus.be), 32'd0);
    check("sb8.scnt", 32'(store_cnt), 32'd1);
    check("sb8.b8", 32'(mem[2][7:0]), 32'h78);
    check("sb8.b9", 32'(mem[2][15:8]), 32'hBA);
    check("sb8.b7", 32'(mem[1][31:24]), 32'h11);
    next_cyc();

    do_store("w2", 2'b10, 32'd8, 32'h00AB_80FF,
             4'b1111, 32'h00AB_80FF);
    do_load("lb9", 2'b00, 1'b0, 32'd9, 5'd3, 32'hFFFF_FF80);
    do_load("lbu9", 2'b00, 1'b1, 32'd9, 5'd4, 32'h0000_0080);
    do_load("lh10", 2'b01, 1'b0, 32'd10, 5'd5, 32'h0000_00AB);
    @(negedge clk);
    check("ld.lcnt", 32'(load_cnt), 32'd3);
    next_cyc();

    do_store("sh6", 2'b01, 32'd6, 32'h0000_BEEF,
             4'b1100, 32'hBEEF_BEEF);
    do_load("lw4", 2'b10, 1'b0, 32'd4, 5'd6, 32'hBEEF_3344);

    do_bad("lh3", 1'b1, 1'b0, 2'b01, 32'd3);
    do_bad("sw6", 1'b0, 1'b1, 2'b10, 32'd6);
    do_bad("rw", 1'b1, 1'b1, 2'b10, 32'd8);
    do_bad("sz3", 1'b1, 1'b0, 2'b11, 32'd8);
    @(negedge clk);
    check("bad.scnt", 32'(store_cnt), 32'(exp_st));
    check("bad.lcnt", 32'(load_cnt), 32'd4);
    check("bad.ov", 32'(out_valid), 32'd0);
    next_cyc();

    req(1'b1, 1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 5'd7);
    @(negedge clk);
    check("rlw.stall0", 32'(stall), 32'd1);
    next_cyc();
    rst = 1'b1;
    idle();
    next_cyc();
    rst = 1'b0;
    exp_st = 0;
    @(negedge clk);
    check("rlw.ov", 32'(out_valid), 32'd0);
    check("rlw.lcnt", 32'(load_cnt), 32'd0);
    check("rlw.stall", 32'(stall), 32'd0);
    next_cyc();
    @(negedge clk);
    check("rlw.ov2", 32'(out_valid), 32'd0);
    next_cyc();

    do_store("sb21", 2'b00, 32'h21, 32'h0000_00A5,
             4'b0010, 32'hA5A5_A5A5);
    idle();
    @(negedge clk);
    check("sb21.scnt", 32'(store_cnt), 32'd1);
    next_cyc();

    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h5555_AAAA, 5'd0);
    repeat (65535 - exp_st) @(posedge clk);
    #1 idle();
    @(negedge clk);
    check("wrap.max", 32'(store_cnt), 32'h0000_FFFF);
    next_cyc();
    exp_st = 0;
    do_store("wrap", 2'b10, 32'h40, 32'h1357_9BDF,
             4'b1111, 32'h1357_9BDF);
    idle();
    @(negedge clk);
    check("wrap.zero", 32'(store_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
